// File: rtl/tdm_demux.sv
// Receive-side demultiplexer for a two-channel TDM stream (A tagged by sync, then B).
// Tracks frame alignment, steers beats into per-channel holding registers, counts frames/errors.
module tdm_demux #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             sync,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  output logic             a_valid,
  output logic             b_valid,
  output logic             frame_valid,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [7:0]       err_cnt
);

  typedef enum logic [1:0] {
    StHunt  = 2'd0,
    StWaitB = 2'd1,
    StWaitA = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic take_a, take_b, viol;

  logic [WIDTH-1:0] a_q, b_q;
  logic             a_valid_q, b_valid_q, frame_valid_q, err_q;
  logic [CNT_W-1:0] frame_cnt_q;
  logic [7:0]       err_cnt_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StHunt;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (din_valid) begin
      unique case (state_q)
        StHunt:  if (sync) state_d = StWaitB;
        StWaitB: if (!sync) state_d = StWaitA;
        StWaitA: state_d = sync ? StWaitB : StHunt;
        default: state_d = StHunt;
      endcase
    end
  end

  // Beat steering decode
  always_comb begin
    take_a = 1'b0;
    take_b = 1'b0;
    viol   = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        StHunt: begin
          take_a = sync;
        end
        StWaitB: begin
          // A sync here means B went missing: flag it and restart on this beat as A.
          take_a = sync;
          take_b = !sync;
          viol   = sync;
        end
        StWaitA: begin
          take_a = sync;
          viol   = !sync;
        end
        default: begin
          take_a = 1'b0;
        end
      endcase
    end
  end

  // Datapath, strobes and counters
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q           <= '0;
      b_q           <= '0;
      a_valid_q     <= 1'b0;
      b_valid_q     <= 1'b0;
      frame_valid_q <= 1'b0;
      err_q         <= 1'b0;
      frame_cnt_q   <= '0;
      err_cnt_q     <= '0;
    end else begin
      a_valid_q     <= take_a;
      b_valid_q     <= take_b;
      frame_valid_q <= take_b;
      err_q         <= viol;
      if (take_a) a_q <= din;
      if (take_b) begin
        b_q         <= din;
        frame_cnt_q <= frame_cnt_q + CNT_W'(1);
      end
      if (viol && (err_cnt_q != 8'hFF)) err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  always_comb begin
    a_out       = a_q;
    b_out       = b_q;
    a_valid     = a_valid_q;
    b_valid     = b_valid_q;
    frame_valid = frame_valid_q;
    err         = err_q;
    frame_cnt   = frame_cnt_q;
    err_cnt     = err_cnt_q;
    locked      = (state_q != StHunt);
  end

endmodule

// File: tb/tb_tdm_demux.sv
// Randomized self-checking bench for tdm_demux against a behavioural frame-tracking model.
// A second instance with CNT_W=4 shares the stimulus to exercise frame counter wrap.
module tb_tdm_demux;

  logic       clk = 1'b0;
  logic       rst, din_valid, sync;
  logic [7:0] din;

  logic [7:0]  a_out, b_out, err_cnt;
  logic        a_valid, b_valid, frame_valid, locked, err;
  logic [15:0] frame_cnt;

  logic [7:0] s_a_out, s_b_out, s_err_cnt;
  logic       s_a_valid, s_b_valid, s_frame_valid, s_locked, s_err;
  logic [3:0] s_frame_cnt;

  int total = 0;
  int bad   = 0;

  // Model: phase 0 = no alignment, 1 = expecting B, 2 = expecting A
  int         m_phase;
  logic [7:0] m_a, m_b;
  logic       m_av, m_bv, m_fv, m_err;
  int         m_frames, m_errs;

  always #5 clk = ~clk;

  tdm_demux #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
    .a_out(a_out), .b_out(b_out), .a_valid(a_valid), .b_valid(b_valid),
    .frame_valid(frame_valid), .locked(locked), .err(err),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  tdm_demux #(.WIDTH(8), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sync(sync),
    .a_out(s_a_out), .b_out(s_b_out), .a_valid(s_a_valid), .b_valid(s_b_valid),
    .frame_valid(s_frame_valid), .locked(s_locked), .err(s_err),
    .frame_cnt(s_frame_cnt), .err_cnt(s_err_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic s, input logic [7:0] d);
    m_av = 1'b0; m_bv = 1'b0; m_fv = 1'b0; m_err = 1'b0;
    if (r) begin
      m_phase = 0; m_a = 8'h00; m_b = 8'h00; m_frames = 0; m_errs = 0;
    end else if (v) begin
      if (s) begin
        if (m_phase == 1) begin
          m_err = 1'b1;
          if (m_errs < 255) m_errs++;
        end
        m_a = d; m_av = 1'b1; m_phase = 1;
      end else if (m_phase == 1) begin
        m_b = d; m_bv = 1'b1; m_fv = 1'b1; m_frames++; m_phase = 2;
      end else if (m_phase == 2) begin
        m_err = 1'b1;
        if (m_errs < 255) m_errs++;
        m_phase = 0;
      end
    end
  endtask

  task automatic check_all();
    check("a_out", 32'(a_out), 32'(m_a));
    check("b_out", 32'(b_out), 32'(m_b));
    check("a_valid", 32'(a_valid), 32'(m_av));
    check("b_valid", 32'(b_valid), 32'(m_bv));
    check("frame_valid", 32'(frame_valid), 32'(m_fv));
    check("locked", 32'(locked), 32'(m_phase != 0));
    check("err", 32'(err), 32'(m_err));
    check("frame_cnt", 32'(frame_cnt), 32'(m_frames % 65536));
    check("err_cnt", 32'(err_cnt), 32'(m_errs));
    check("small_frame_cnt", 32'(s_frame_cnt), 32'(m_frames % 16));
    check("small_locked", 32'(s_locked), 32'(m_phase != 0));
  endtask

  task automatic cycle(input logic r, input logic v, input logic s, input logic [7:0] d);
    rst = r; din_valid = v; sync = s; din = d;
    @(posedge clk);
    #1;
    model_step(r, v, s, d);
    check_all();
  endtask

  initial begin
    rst = 1'b1; din_valid = 1'b0; sync = 1'b0; din = 8'h00;
    m_phase = 0; m_a = 0; m_b = 0; m_frames = 0; m_errs = 0;
    m_av = 0; m_bv = 0; m_fv = 0; m_err = 0;

    // Reset with a concurrent beat that must be dropped
    cycle(1'b1, 1'b1, 1'b1, 8'hAA);
    check("rst_a_out", 32'(a_out), 32'h0);

    // Two back-to-back frames
    cycle(1'b0, 1'b1, 1'b1, 8'h11);
    cycle(1'b0, 1'b1, 1'b0, 8'h22);
    cycle(1'b0, 1'b1, 1'b1, 8'h33);
    cycle(1'b0, 1'b1, 1'b0, 8'h44);
    check("t1_a_out", 32'(a_out), 32'h33);
    check("t1_b_out", 32'(b_out), 32'h44);
    check("t1_frame_cnt", 32'(frame_cnt), 32'd2);
    check("t1_err_cnt", 32'(err_cnt), 32'd0);

    // Hunting: unsynced beats ignored without error
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 8'h05);
    cycle(1'b0, 1'b1, 1'b0, 8'h06);
    check("t2_no_err", 32'(err_cnt), 32'd0);
    check("t2_unlocked", 32'(locked), 32'd0);
    cycle(1'b0, 1'b1, 1'b1, 8'h07);
    check("t2_locked", 32'(locked), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 8'h08);
    check("t2_frame", 32'(frame_valid), 32'd1);

    // WAIT_A with missing sync
    cycle(1'b0, 1'b1, 1'b0, 8'h77);
    check("t4_err", 32'(err), 32'd1);
    check("t4_b_hold", 32'(b_out), 32'h08);
    check("t4_unlocked", 32'(locked), 32'd0);

    // WAIT_B with missing B
    cycle(1'b0, 1'b1, 1'b1, 8'h09);
    cycle(1'b0, 1'b1, 1'b1, 8'h55);
    check("t3_err", 32'(err), 32'd1);
    check("t3_a_out", 32'(a_out), 32'h55);
    check("t3_locked", 32'(locked), 32'd1);
    cycle(1'b0, 1'b1, 1'b0, 8'h66);
    check("t3_frame", 32'(frame_valid), 32'd1);
    check("t3_b_out", 32'(b_out), 32'h66);

    // Partial frame, long gap, reset, then orphan B
    cycle(1'b0, 1'b1, 1'b1, 8'h3C);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'($urandom), 8'($urandom));
    check("t6_gap_locked", 32'(locked), 32'd1);
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    cycle(1'b0, 1'b1, 1'b0, 8'h5A);
    check("t6_no_frame", 32'(frame_valid), 32'd0);
    check("t6_a_out", 32'(a_out), 32'h0);
    check("t6_b_out", 32'(b_out), 32'h0);

    // Error counter saturation
    for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1, 1'b1, 8'(i));
    check("t5_err_sat", 32'(err_cnt), 32'd255);
    check("t5_err_pulse", 32'(err), 32'd1);

    // 16 frames with gaps wrap the 4-bit counter
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      cycle(1'b0, 1'b1, 1'b1, 8'(i));
      if (i % 3 == 0) cycle(1'b0, 1'b0, 1'b1, 8'hFF);
      cycle(1'b0, 1'b1, 1'b0, 8'(i + 100));
    end
    check("t5_small_wrap", 32'(s_frame_cnt), 32'd0);
    check("t5_frames16", 32'(frame_cnt), 32'd16);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 3) != 0),
            1'($urandom), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
